// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the response-path mux.
// Holds HTRANS/HRESP codes, the data-phase select and default-FSM enums.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    DSEL_NONE,
    DSEL_S1,
    DSEL_S2,
    DSEL_S3,
    DSEL_DEF
  } dsel_e;

  typedef enum logic [1:0] {
    DS_OK,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  function automatic logic [2:0] sel_count(
    input logic [3:0] sel
  );
    sel_count = 3'(sel[0]) + 3'(sel[1])
              + 3'(sel[2]) + 3'(sel[3]);
  endfunction

endpackage

// File: rtl/ahb_default_sub.sv
// Default subordinate: two-cycle ERROR for hits on
// default or unmapped space, zero-wait OKAY otherwise.
module ahb_default_sub
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic i_hit,
  output logic o_ready,
  output logic o_resp
);

  ds_state_e r_state;
  ds_state_e w_next;

  // State register with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= DS_OK;
    else        r_state <= w_next;
  end

  // Next state and response outputs
  always_comb begin
    w_next  = r_state;
    o_ready = 1'b1;
    o_resp  = HRESP_OKAY;
    unique case (r_state)
      DS_OK: begin
        if (i_hit) w_next = DS_ERR1;
      end
      DS_ERR1: begin
        o_ready = 1'b0;
        o_resp  = HRESP_ERROR;
        w_next  = DS_ERR2;
      end
      DS_ERR2: begin
        o_resp = HRESP_ERROR;
        w_next = i_hit ? DS_ERR1 : DS_OK;
      end
      default: w_next = DS_OK;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite subordinate-to-manager response mux.
// Option AHB_RESP_MUX_MULTISEL_ERR_EN: multi-select errors.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL1,
  input  logic                  HSEL2,
  input  logic                  HSEL3,
  input  logic                  HSELd,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADYOUT1,
  input  logic                  HREADYOUT2,
  input  logic                  HREADYOUT3,
  input  logic                  HRESP1,
  input  logic                  HRESP2,
  input  logic                  HRESP3,
  input  logic [DATA_WIDTH-1:0] HRDATA1,
  input  logic [DATA_WIDTH-1:0] HRDATA2,
  input  logic [DATA_WIDTH-1:0] HRDATA3,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  dsel_e                 r_dsel;
  dsel_e                 w_dsel_d;
  logic                  w_active;
  logic                  w_hit;
  logic                  w_ds_ready;
  logic                  w_ds_resp;
  logic                  w_hready;
  logic                  w_hresp;
  logic [DATA_WIDTH-1:0] w_hrdata;
`ifdef AHB_RESP_MUX_MULTISEL_ERR_EN
  logic                  w_multi;
`endif

  assign w_active = (HTRANS == HTRANS_NONSEQ)
                 || (HTRANS == HTRANS_SEQ);

  // Address-phase decode of the select lines
  always_comb begin
    w_dsel_d = DSEL_NONE;
    if      (HSEL1) w_dsel_d = DSEL_S1;
    else if (HSEL2) w_dsel_d = DSEL_S2;
    else if (HSEL3) w_dsel_d = DSEL_S3;
    else if (HSELd) w_dsel_d = DSEL_DEF;
`ifdef AHB_RESP_MUX_MULTISEL_ERR_EN
    w_multi = sel_count({HSELd, HSEL3, HSEL2, HSEL1}) > 3'd1;
    if (w_multi)
      w_dsel_d = w_active ? DSEL_DEF : DSEL_NONE;
`endif
  end

  // Active transfer accepted into default/unmapped space
  assign w_hit = w_hready && w_active
              && ((w_dsel_d == DSEL_DEF)
               || (w_dsel_d == DSEL_NONE));

  // Data-phase select, frozen across wait states
  always_ff @(posedge HCLK) begin
    if (HRESET)       r_dsel <= DSEL_NONE;
    else if (w_hready) r_dsel <= w_dsel_d;
  end

  ahb_default_sub u_def (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .i_hit   (w_hit),
    .o_ready (w_ds_ready),
    .o_resp  (w_ds_resp)
  );

  // Zero-latency return mux keyed by the data-phase owner
  always_comb begin
    w_hready = w_ds_ready;
    w_hresp  = w_ds_resp;
    w_hrdata = DEFAULT_RDATA;
    unique case (r_dsel)
      DSEL_S1: begin
        w_hready = HREADYOUT1;
        w_hresp  = HRESP1;
        w_hrdata = HRDATA1;
      end
      DSEL_S2: begin
        w_hready = HREADYOUT2;
        w_hresp  = HRESP2;
        w_hrdata = HRDATA2;
      end
      DSEL_S3: begin
        w_hready = HREADYOUT3;
        w_hresp  = HRESP3;
        w_hrdata = HRDATA3;
      end
      default: begin
        w_hready = w_ds_ready;
        w_hresp  = w_ds_resp;
        w_hrdata = DEFAULT_RDATA;
      end
    endcase
  end

  assign HREADY = w_hready;
  assign HRESP  = w_hresp;
  assign HRDATA = w_hrdata;

endmodule
